// File: rtl/chip_bus_pkg.sv
// Shared widths, types and helpers for the chip bus method block.
// The call counters are only built when CHIP_BUS_CALL_COUNT_EN is defined.
package chip_bus_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Folds the two halves of a request word into a bus address (base not applied).
    function automatic addr_t fold_addr(input data_t d);
        return d[DATA_W-1:ADDR_W] ^ d[ADDR_W-1:0];
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/chip_bus_parity.sv
// Parity method: 64-bit XOR reduction with optional inversion, registered.
// Every par_valid cycle is accepted; the result pulses par_rsp_valid one cycle later.
module chip_bus_parity
    import chip_bus_pkg::*;
#(
    parameter logic ODD_PARITY = 1'b0
) (
    input  logic  clock,
    input  logic  resetN,
    input  logic  par_valid,
    input  data_t par_data,
    output logic  par_rsp_valid,
    output logic  par_out
);

    logic par_bit;

    assign par_bit = (^par_data) ^ ODD_PARITY;

    always_ff @(posedge clock) begin
        if (resetN) begin
            par_rsp_valid <= 1'b0;
            par_out       <= 1'b0;
        end else begin
            par_rsp_valid <= par_valid;
            // Result holds between requests so a late reader still sees the last value.
            if (par_valid) begin
                par_out <= par_bit;
            end
        end
    end

endmodule

// File: rtl/chip_bus_modport.sv
// Chip bus method block: Read (address fold) and Parity_gen channels.
// Optional saturating call counters are built when CHIP_BUS_CALL_COUNT_EN is defined.
module chip_bus_modport
    import chip_bus_pkg::*;
#(
    parameter addr_t BASE_ADDR  = 32'h0000_0000,
    parameter logic  ODD_PARITY = 1'b0
) (
    input  logic  clock,
    input  logic  resetN,
    input  logic  rd_valid,
    output logic  rd_ready,
    input  data_t rd_data,
    output logic  rd_rsp_valid,
    input  logic  rd_rsp_ready,
    output addr_t rd_address,
    input  logic  par_valid,
    input  data_t par_data,
    output logic  par_rsp_valid,
    output logic  par_out,
    output cnt_t  rd_count,
    output cnt_t  par_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never depends on ready, and a raised response valid holds, with its data
    // stable, until the matching ready is seen.
    logic rd_accept;

    // One-entry response slot: a new request may enter whenever the slot is empty
    // or is being drained in this same cycle.
    assign rd_ready  = !rd_rsp_valid || rd_rsp_ready;
    assign rd_accept = rd_valid && rd_ready;

    always_ff @(posedge clock) begin
        if (resetN) begin
            rd_rsp_valid <= 1'b0;
            rd_address   <= '0;
        end else if (rd_accept) begin
            rd_rsp_valid <= 1'b1;
            rd_address   <= fold_addr(rd_data) + BASE_ADDR;
        end else if (rd_rsp_ready) begin
            rd_rsp_valid <= 1'b0;
        end
    end

    chip_bus_parity #(
        .ODD_PARITY (ODD_PARITY)
    ) u_parity (
        .clock         (clock),
        .resetN        (resetN),
        .par_valid     (par_valid),
        .par_data      (par_data),
        .par_rsp_valid (par_rsp_valid),
        .par_out       (par_out)
    );

`ifdef CHIP_BUS_CALL_COUNT_EN
    cnt_t rd_cnt_q;
    cnt_t par_cnt_q;

    always_ff @(posedge clock) begin
        if (resetN) begin
            rd_cnt_q  <= '0;
            par_cnt_q <= '0;
        end else begin
            if (rd_accept) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (par_valid) begin
                par_cnt_q <= sat_inc(par_cnt_q);
            end
        end
    end

    assign rd_count  = rd_cnt_q;
    assign par_count = par_cnt_q;
`else
    assign rd_count  = '0;
    assign par_count = '0;
`endif

endmodule

// File: tb/tb_chip_bus_modport.sv
// Bench for chip_bus_modport: two instances (default parameters, and wrapping
// base with odd parity) driven from shared inputs and checked against a queue model.
module tb_chip_bus_modport;

    logic        clock = 1'b0;
    logic        resetN;
    logic        rd_valid;
    logic        rd_rsp_ready;
    logic [63:0] rd_data;
    logic        par_valid;
    logic [63:0] par_data;

    logic        rd_ready0, rd_rsp_valid0, par_rsp_valid0, par_out0;
    logic [31:0] rd_address0;
    logic [15:0] rd_count0, par_count0;
    logic        rd_ready1, rd_rsp_valid1, par_rsp_valid1, par_out1;
    logic [31:0] rd_address1;
    logic [15:0] rd_count1, par_count1;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFF;

    int checks = 0;
    int errors = 0;

    // Model: pending Read requests (raw data words), parity result and call totals.
    logic [63:0] exp_q[$];
    logic        exp_par_valid = 1'b0;
    logic        exp_par_ones_odd = 1'b0;
    int          exp_rd_n = 0;
    int          exp_par_n = 0;

    always #5 clock = ~clock;

    chip_bus_modport dut0 (
        .clock         (clock),
        .resetN        (resetN),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready0),
        .rd_data       (rd_data),
        .rd_rsp_valid  (rd_rsp_valid0),
        .rd_rsp_ready  (rd_rsp_ready),
        .rd_address    (rd_address0),
        .par_valid     (par_valid),
        .par_data      (par_data),
        .par_rsp_valid (par_rsp_valid0),
        .par_out       (par_out0),
        .rd_count      (rd_count0),
        .par_count     (par_count0)
    );

    chip_bus_modport #(
        .BASE_ADDR  (BASE1),
        .ODD_PARITY (1'b1)
    ) dut1 (
        .clock         (clock),
        .resetN        (resetN),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready1),
        .rd_data       (rd_data),
        .rd_rsp_valid  (rd_rsp_valid1),
        .rd_rsp_ready  (rd_rsp_ready),
        .rd_address    (rd_address1),
        .par_valid     (par_valid),
        .par_data      (par_data),
        .par_rsp_valid (par_rsp_valid1),
        .par_out       (par_out1),
        .rd_count      (rd_count1),
        .par_count     (par_count1)
    );

    function automatic logic [31:0] exp_addr(input logic [63:0] d, input logic [31:0] base);
        longint unsigned sum;
        sum = longint'(d[63:32] ^ d[31:0]) + longint'(base);
        return 32'(sum % 64'h1_0000_0000);
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef CHIP_BUS_CALL_COUNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n >= 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        logic exp_ready;
        @(negedge clock);
        exp_ready = (exp_q.size() == 0) || rd_rsp_ready;
        chk("rd_ready0", rd_ready0, exp_ready);
        chk("rd_ready1", rd_ready1, exp_ready);
        chk("rd_rsp_valid0", rd_rsp_valid0, exp_q.size() != 0);
        chk("rd_rsp_valid1", rd_rsp_valid1, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("rd_address0", rd_address0, exp_addr(exp_q[0], BASE0));
            chk("rd_address1", rd_address1, exp_addr(exp_q[0], BASE1));
        end
        chk("par_rsp_valid0", par_rsp_valid0, exp_par_valid);
        chk("par_rsp_valid1", par_rsp_valid1, exp_par_valid);
        if (exp_par_valid) begin
            chk("par_out_even", par_out0, exp_par_ones_odd);
            chk("par_out_odd", par_out1, !exp_par_ones_odd);
        end
        chk("rd_count0", rd_count0, exp_cnt(exp_rd_n));
        chk("rd_count1", rd_count1, exp_cnt(exp_rd_n));
        chk("par_count0", par_count0, exp_cnt(exp_par_n));
        chk("par_count1", par_count1, exp_cnt(exp_par_n));
        if (resetN) begin
            exp_q.delete();
            exp_par_valid = 1'b0;
            exp_rd_n = 0;
            exp_par_n = 0;
        end else begin
            if (exp_q.size() != 0 && rd_rsp_ready) begin
                void'(exp_q.pop_front());
            end
            if (rd_valid && exp_ready) begin
                exp_q.push_back(rd_data);
                exp_rd_n++;
            end
            exp_par_valid = par_valid;
            if (par_valid) begin
                exp_par_ones_odd = ($countones(par_data) % 2) == 1;
                exp_par_n++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rd_req(input logic v, input logic [63:0] d, input logic rdy);
        rd_valid     = v;
        rd_data      = d;
        rd_rsp_ready = rdy;
    endtask

    task automatic par_req(input logic v, input logic [63:0] d);
        par_valid = v;
        par_data  = d;
    endtask

    task automatic reset_values_chk();
        @(negedge clock);
        chk("rst_addr0", rd_address0, 32'h0);
        chk("rst_addr1", rd_address1, 32'h0);
        chk("rst_par_out0", par_out0, 1'b0);
        chk("rst_par_out1", par_out1, 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held two cycles with both channels requesting.
        resetN = 1'b1;
        rd_req(1'b1, {$urandom, $urandom}, 1'b0);
        par_req(1'b1, 64'h7);
        @(posedge clock);
        #1;
        reset_values_chk();
        cycle();
        resetN = 1'b0;
        rd_req(1'b0, 64'h0, 1'b1);
        par_req(1'b0, 64'h0);
        cycle();

        // Read basic and the wrapping base on the second instance.
        rd_req(1'b1, 64'h0000_0001_0000_0002, 1'b1);
        cycle();
        rd_req(1'b1, 64'h0, 1'b1);
        cycle();
        rd_req(1'b1, 64'h0000_0000_0000_0001, 1'b1);
        cycle();
        rd_req(1'b0, 64'h0, 1'b1);
        cycle();
        cycle();

        // Backpressure: response must hold while the consumer stalls.
        rd_req(1'b1, {$urandom, $urandom}, 1'b0);
        cycle();
        rd_req(1'b1, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        rd_rsp_ready = 1'b1;
        cycle();
        rd_req(1'b0, 64'h0, 1'b1);
        cycle();
        cycle();

        // Parity directed values, separated so each pulse is isolated.
        par_req(1'b1, 64'hFF);
        cycle();
        par_req(1'b0, 64'h0);
        cycle();
        par_req(1'b1, 64'h7);
        cycle();
        par_req(1'b0, 64'h0);
        cycle();
        cycle();

        // Concurrent back-to-back traffic on both channels.
        for (int i = 0; i < 4; i++) begin
            rd_req(1'b1, {$urandom, $urandom}, 1'b1);
            par_req(1'b1, {$urandom, $urandom});
            cycle();
        end
        rd_req(1'b0, 64'h0, 1'b1);
        par_req(1'b0, 64'h0);
        cycle();
        cycle();

        // Randomized mixed traffic with random consumer stalls.
        for (int i = 0; i < 300; i++) begin
            rd_req(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
            par_req(1'($urandom_range(0, 1)), {$urandom, $urandom});
            cycle();
        end

        // Reset with a stalled response pending must discard it.
        rd_req(1'b1, {$urandom, $urandom}, 1'b0);
        par_req(1'b1, {$urandom, $urandom});
        cycle();
        resetN = 1'b1;
        cycle();
        resetN = 1'b0;
        rd_req(1'b0, 64'h0, 1'b0);
        par_req(1'b0, 64'h0);
        chk("midrst_addr0", rd_address0, 32'h0);
        chk("midrst_addr1", rd_address1, 32'h0);
        cycle();
        rd_req(1'b1, 64'h0000_00AB_0000_0010, 1'b1);
        cycle();
        rd_req(1'b0, 64'h0, 1'b1);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip_bus_modport.md
# chip_bus_modport

Bus-side method block for the chip bus. It exposes two request channels:

- **Read**: takes a 64-bit data word and returns a 32-bit bus address.
- **Parity_gen**: takes a 64-bit data word and returns a single parity bit.

It sits between a chip's datapath and the shared chip bus, with both methods implemented in hardware with explicit handshakes. Optional per-method call counters support debug visibility.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: offset added to every Read address, modulo 2^32.
- ODD_PARITY, 1'b0: 0 selects even parity (XOR reduction); 1 selects odd parity (inverted XOR reduction).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- resetN  input  1  reset, synchronous and active-high (asserted = 1).
- rd_valid  input  1  Read request valid.
- rd_ready  output  1  Read request accepted when rd_valid && rd_ready.
- rd_data  input  64  Read request data.
- rd_rsp_valid  output  1  Read response valid.
- rd_rsp_ready  input  1  consumer accepts the response.
- rd_address  output  32  Read response address.
- par_valid  input  1  parity request strobe.
- par_data  input  64  parity request data.
- par_rsp_valid  output  1  parity result valid, one-cycle pulse.
- par_out  output  1  parity result.
- rd_count  output  16  saturating count of accepted Read requests.
- par_count  output  16  saturating count of accepted parity requests.

## Operation
- **Read address**: rd_address = (rd_data[63:32] ^ rd_data[31:0]) + BASE_ADDR. The result is truncated to 32 bits, so it wraps with no carry out.
- **Read channel**: one-entry registered response.
  - rd_ready = !rd_rsp_valid || rd_rsp_ready.
  - On accept, the address is captured and rd_rsp_valid is set.
  - rd_rsp_valid clears when rd_rsp_ready is high and there is no new accept in the same cycle.
  - Accept and response consume in the same cycle: the new address replaces the old one and rd_rsp_valid stays 1.
- **Parity channel**: no backpressure; every par_valid cycle is accepted.
  - par_out = (^par_data) ^ ODD_PARITY, registered.
  - par_rsp_valid is par_valid delayed by one cycle.
  - Back-to-back par_valid cycles produce back-to-back results.
- **Independence**: the two channels never block each other. Simultaneous Read and parity requests are both served in the same cycle.
- **Counters**:
  - rd_count increments on each Read accept; par_count increments on each par_valid.
  - Both saturate at 16'hFFFF and do not wrap.
- **Reset** (resetN = 1 at a clock edge):
  - rd_rsp_valid, rd_address, par_rsp_valid, par_out, rd_count and par_count all go to 0.
  - rd_ready is 1 in the cycle after reset.
  - Requests presented while resetN = 1 are ignored and not counted.
  - Reset mid-operation discards any pending response.

## Timing
- Read latency: an accept at edge N makes the response visible after edge N, with rd_rsp_valid = 1 in cycle N+1.
- Read throughput: one request per cycle while rd_rsp_ready is held high.
- Read stall: rd_rsp_valid and rd_address hold stable until the response is consumed.
- Parity latency: one cycle. Parity throughput: one per cycle.
- Counters update on the same edge as the accept.
- No combinational path from rd_data or par_data to any output. The only combinational path is rd_rsp_ready -> rd_ready.

## Configuration
- Macro CHIP_BUS_CALL_COUNT_EN.
- Defined: rd_count and par_count behave as specified above.
- Undefined: counter logic is not built, rd_count and par_count are tied to 16'h0000, and all other behaviour is unchanged.

## Structure
- Package chip_bus_pkg holds:
  - constants DATA_W = 64, ADDR_W = 32, CNT_W = 16;
  - typedefs data_t and addr_t;
  - function fold_addr(data_t) returning addr_t.
- Sub-module chip_bus_parity holds the 64-bit XOR tree, the ODD_PARITY invert and the output register. The top level holds the Read channel and the counters.

## Test plan
- Reset: hold resetN = 1 for 2 cycles with both requests active -> all outputs 0, counts 0; rd_ready = 1 after release.
- Read basic: rd_data = 64'h0000_0001_0000_0002 with BASE_ADDR = 0 -> next cycle rd_rsp_valid = 1, rd_address = 32'h0000_0003, rd_count = 1.
- Read wrap and backpressure:
  - Use BASE_ADDR = 32'hFFFF_FFFF and rd_data = 64'h0 -> rd_address = 32'hFFFF_FFFF.
  - Then rd_data = 64'h0000_0000_0000_0001 -> rd_address = 32'h0000_0000.
  - Hold rd_rsp_ready = 0 -> rd_ready = 0 and the address stays stable until ready.
- Parity:
  - ODD_PARITY = 0: par_data = 64'hFF -> par_out = 0; par_data = 64'h7 -> par_out = 1; each result arrives with a one-cycle par_rsp_valid.
  - ODD_PARITY = 1: the same inputs give 1 and 0.
- Concurrent: Read and parity requests in the same cycle, 4 back-to-back each -> 4 responses per channel in order, rd_count = par_count = 4.
- Configuration: build without CHIP_BUS_CALL_COUNT_EN, issue 3 requests per channel -> counts remain 0 and responses are identical to the counted build.
